// File: rtl/riscv_dift_tag_policy_unit.sv
// ---------------------------------------------------------------------------
// riscv_dift_tag_policy_unit
//
// DIFT tag-propagation engine that sits beside the EX stage of a tagged RISC-V
// datapath. It holds two CSR-programmable tables:
//   * policy     : 2-bit propagation mode per instruction class
//                  (class i owns bits [2i+1:2i]).
//   * check mask : 1 bit per class. A set bit means a tainted source traps.
// For every accepted op it either registers the propagated rd tag (one cycle
// later, towards the tag register file) or raises a trap. The trap holds until
// the handler acknowledges it, and a saturating trap counter is incremented.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   csr_op_i          00 none, 01 write, 10 set, 11 clear
//   csr_sel_i         0 policy, 1 check mask, 2 trap counter, 3 reserved
//   csr_wdata_i       CSR operand
//   csr_rdata_o       combinational read of the selected CSR (zero-extended)
//   in_valid_i/in_ready_o           op handshake
//   in_class_i, in_tag_{a,b,rd}_i   op class and source/destination tags
//   out_valid_o/out_ready_i         result handshake
//   out_tag_o                       propagated rd tag
//   trap_o, trap_class_o, trap_ack_i  tag-check violation and acknowledge
// ---------------------------------------------------------------------------
module riscv_dift_tag_policy_unit #(
  parameter int          NUM_CLASSES = 7,
  parameter int          TAG_W       = 1,
  parameter int          CNT_W       = 8,
  parameter logic [31:0] POLICY_RST  = 32'h0,
  parameter logic [31:0] CHECK_RST   = 32'h0,
  localparam int         CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       csr_op_i,
  input  logic [1:0]       csr_sel_i,
  input  logic [31:0]      csr_wdata_i,
  output logic [31:0]      csr_rdata_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [CLS_W-1:0] in_class_i,
  input  logic [TAG_W-1:0] in_tag_a_i,
  input  logic [TAG_W-1:0] in_tag_b_i,
  input  logic [TAG_W-1:0] in_tag_rd_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             trap_o,
  output logic [CLS_W-1:0] trap_class_o,
  input  logic             trap_ack_i
);

  localparam int POL_W = 2 * NUM_CLASSES;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    SEL_POLICY = 2'd0,
    SEL_MASK   = 2'd1,
    SEL_COUNT  = 2'd2,
    SEL_RSVD   = 2'd3
  } csr_sel_e;

  typedef enum logic [1:0] {
    MODE_OLD   = 2'b00,
    MODE_AND   = 2'b01,
    MODE_OR    = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_TRAP = 1'b1
  } state_e;

  // Architectural state
  logic [POL_W-1:0]       policy_q;
  logic [NUM_CLASSES-1:0] mask_q;
  logic [CNT_W-1:0]       cnt_q;
  state_e                 state_q, state_d;
  logic                   out_valid_q;
  logic [TAG_W-1:0]       out_tag_q;
  logic [CLS_W-1:0]       trap_class_q;

  // Combinational helpers
  csr_op_e                csr_op;
  csr_sel_e               csr_sel;
  logic [31:0]            policy_upd, mask_upd;
  logic [POL_W-1:0]       policy_d;
  logic [NUM_CLASSES-1:0] mask_d;
  mode_e                  mode;
  logic                   checked;
  logic                   violation;
  logic                   accept;
  logic [TAG_W-1:0]       result;

  assign csr_op  = csr_op_e'(csr_op_i);
  assign csr_sel = csr_sel_e'(csr_sel_i);

  // Applies a CSR write/set/clear to a zero-extended register image.
  function automatic logic [31:0] csr_apply(input logic [31:0] cur,
                                            input csr_op_e     op,
                                            input logic [31:0] wd);
    logic [31:0] r;
    r = cur;
    case (op)
      CSR_WRITE: r = wd;
      CSR_SET:   r = cur | wd;
      CSR_CLEAR: r = cur & ~wd;
      default:   r = cur;
    endcase
    return r;
  endfunction

  // CSR next values; operand bits above the register width fall away in the slice.
  always_comb begin
    policy_upd = csr_apply(32'(policy_q), csr_op, csr_wdata_i);
    mask_upd   = csr_apply(32'(mask_q), csr_op, csr_wdata_i);
    policy_d   = (csr_sel == SEL_POLICY) ? policy_upd[POL_W-1:0]     : policy_q;
    mask_d     = (csr_sel == SEL_MASK)   ? mask_upd[NUM_CLASSES-1:0] : mask_q;
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_sel)
      SEL_POLICY: csr_rdata_o = 32'(policy_q);
      SEL_MASK:   csr_rdata_o = 32'(mask_q);
      SEL_COUNT:  csr_rdata_o = 32'(cnt_q);
      default:    csr_rdata_o = '0;
    endcase
  end

  // Class decode. Out-of-range class indices match no entry, so they keep the
  // OLD mode and are never checked.
  // NOTE: every signal driven here gets a default first, so no path through the
  // block leaves it unassigned and no latch is inferred.
  always_comb begin
    mode    = MODE_OLD;
    checked = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (in_class_i == CLS_W'(i)) begin
        mode    = mode_e'(policy_q[2*i +: 2]);
        checked = mask_q[i];
      end
    end
  end

  assign violation = checked & (|(in_tag_a_i | in_tag_b_i));

  always_comb begin
    result = '0;
    case (mode)
      MODE_OLD:   result = in_tag_rd_i;
      MODE_AND:   result = in_tag_a_i & in_tag_b_i;
      MODE_OR:    result = in_tag_a_i | in_tag_b_i;
      default:    result = '0;
    endcase
  end

  assign in_ready_o = (state_q == S_IDLE) & (~out_valid_q | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && violation) state_d = S_TRAP;
      S_TRAP: if (trap_ack_i)          state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others. This is what makes an
  // op accepted alongside a CSR update see the old policy and mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      policy_q     <= POLICY_RST[POL_W-1:0];
      mask_q       <= CHECK_RST[NUM_CLASSES-1:0];
      cnt_q        <= '0;
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_tag_q    <= '0;
      trap_class_q <= '0;
    end else begin
      policy_q <= policy_d;
      mask_q   <= mask_d;
      state_q  <= state_d;

      // A software clear of the counter takes precedence over a trap increment.
      if (csr_op != CSR_NONE && csr_sel == SEL_COUNT) begin
        cnt_q <= '0;
      end else if (accept && violation && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // A violating op suppresses its result; it never sets out_valid.
      if (accept && !violation) begin
        out_valid_q <= 1'b1;
        out_tag_q   <= result;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end

      if (accept && violation) begin
        trap_class_q <= in_class_i;
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_tag_o    = out_tag_q;
  assign trap_o       = (state_q == S_TRAP);
  assign trap_class_o = trap_class_q;

endmodule

// File: tb/tb_riscv_dift_tag_policy_unit.sv
// ---------------------------------------------------------------------------
// Testbench for riscv_dift_tag_policy_unit (NUM_CLASSES=7, TAG_W=1, CNT_W=2).
// A behavioural model, kept as plain integers, tracks what the outputs must
// be. A negedge process compares the DUT against the model on every cycle.
// Directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_riscv_dift_tag_policy_unit;

  localparam int NC    = 7;
  localparam int CLS_W = 3;
  localparam int CMAX  = 3;        // 2^CNT_W - 1
  localparam int PMASK = 'h3FFF;   // 2*NC policy bits
  localparam int MMASK = 'h7F;     // NC mask bits

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       csr_op, csr_sel;
  logic [31:0]      csr_wdata, csr_rdata;
  logic             in_valid, in_ready;
  logic [CLS_W-1:0] in_class;
  logic             tag_a, tag_b, tag_rd;
  logic             out_valid, out_ready, out_tag;
  logic             trap, trap_ack;
  logic [CLS_W-1:0] trap_class;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  riscv_dift_tag_policy_unit #(
    .NUM_CLASSES(NC), .TAG_W(1), .CNT_W(2),
    .POLICY_RST(32'h0), .CHECK_RST(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .csr_op_i(csr_op), .csr_sel_i(csr_sel), .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_class_i(in_class),
    .in_tag_a_i(tag_a), .in_tag_b_i(tag_b), .in_tag_rd_i(tag_rd),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_tag_o(out_tag),
    .trap_o(trap), .trap_class_o(trap_class), .trap_ack_i(trap_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_policy, m_mask, m_cnt, m_tcls;
  bit m_ov, m_otag, m_trap;

  always @(posedge clk) begin : model
    int  cls, mode, res, nc, pol, msk;
    bit  rdy, acc, viol, taint;
    if (rst) begin
      m_policy <= 0; m_mask <= 0; m_cnt <= 0;
      m_ov <= 1'b0; m_otag <= 1'b0; m_trap <= 1'b0; m_tcls <= 0;
    end else begin
      rdy   = !m_trap && (!m_ov || out_ready);
      acc   = in_valid && rdy;
      cls   = int'(in_class);
      taint = tag_a | tag_b;
      mode  = (cls < NC) ? ((m_policy >> (2 * cls)) & 3) : 0;
      viol  = (cls < NC) && (((m_mask >> cls) & 1) == 1) && taint;
      case (mode)
        0:       res = int'(tag_rd);
        1:       res = int'(tag_a & tag_b);
        2:       res = int'(tag_a | tag_b);
        default: res = 0;
      endcase
      if (acc && !viol) begin
        m_ov <= 1'b1; m_otag <= res[0];
      end else if (out_ready) begin
        m_ov <= 1'b0;
      end
      if (acc && viol) begin
        m_trap <= 1'b1; m_tcls <= cls;
      end else if (m_trap && trap_ack) begin
        m_trap <= 1'b0;
      end
      nc = m_cnt;
      if (acc && viol) nc = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
      if (csr_op != 2'b00 && csr_sel == 2'd2) nc = 0;
      m_cnt <= nc;
      pol = m_policy;
      msk = m_mask;
      case (csr_op)
        2'b01: begin pol = int'(csr_wdata); msk = int'(csr_wdata); end
        2'b10: begin pol = pol | int'(csr_wdata); msk = msk | int'(csr_wdata); end
        2'b11: begin pol = pol & ~int'(csr_wdata); msk = msk & ~int'(csr_wdata); end
        default: ;
      endcase
      if (csr_sel == 2'd0) m_policy <= pol & PMASK;
      if (csr_sel == 2'd1) m_mask   <= msk & MMASK;
    end
  end

  function automatic int exp_rdata();
    case (csr_sel)
      2'd0:    return m_policy;
      2'd1:    return m_mask;
      2'd2:    return m_cnt;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(!m_trap && (!m_ov || out_ready)));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) check("out_tag", 32'(out_tag), 32'(m_otag));
      check("trap", 32'(trap), 32'(m_trap));
      if (m_trap) check("trap_class", 32'(trap_class), m_tcls);
      check("csr_rdata", csr_rdata, exp_rdata());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [1:0] op, input logic [1:0] sel, input logic [31:0] wd);
    csr_op = op; csr_sel = sel; csr_wdata = wd;
    tick();
    csr_op = 2'b00;
  endtask

  task automatic send(input int cls, input logic a, input logic b, input logic rd);
    in_valid = 1'b1; in_class = CLS_W'(cls); tag_a = a; tag_b = b; tag_rd = rd;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic ack();
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; csr_op = 2'b00; csr_sel = 2'd0; csr_wdata = '0;
    in_valid = 1'b0; in_class = '0; tag_a = 1'b0; tag_b = 1'b0; tag_rd = 1'b0;
    out_ready = 1'b1; trap_ack = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_trap", 32'(trap), 0);
    check("rst_policy", csr_rdata, 0);
    check("rst_in_ready", 32'(in_ready), 1);

    // Class 0 = OR
    csr(2'b01, 2'd0, 32'h0000_0002);
    check("policy_write", csr_rdata, 32'h2);
    send(0, 1'b1, 1'b0, 1'b0);
    check("or_valid", 32'(out_valid), 1);
    check("or_tag", 32'(out_tag), 1);
    tick();
    check("drain_valid", 32'(out_valid), 0);

    // Back-pressure: result held while out_ready is low
    out_ready = 1'b0;
    send(0, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b1; in_class = 3'd0; tag_a = 1'b0; tag_b = 1'b0; tag_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ready", 32'(in_ready), 0);
      check("stall_tag", 32'(out_tag), 1);
      check("stall_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("release_valid", 32'(out_valid), 1);
    check("release_tag", 32'(out_tag), 0);
    tick();
    check("release_drain", 32'(out_valid), 0);

    // Violation on class 0
    csr(2'b10, 2'd1, 32'h1);
    check("mask_set", csr_rdata, 32'h1);
    send(0, 1'b1, 1'b0, 1'b0);
    check("viol_trap", 32'(trap), 1);
    check("viol_class", 32'(trap_class), 0);
    check("viol_no_valid", 32'(out_valid), 0);
    check("viol_ready", 32'(in_ready), 0);
    csr_sel = 2'd2;
    #1;
    check("viol_count", csr_rdata, 1);
    tick();
    check("trap_held", 32'(trap), 1);
    ack();
    check("ack_trap", 32'(trap), 0);
    check("ack_ready", 32'(in_ready), 1);
    ack();  // ack while idle is ignored

    // CSR set in the same cycle as a class-1 op: op uses the old (OLD) mode
    csr_op = 2'b10; csr_sel = 2'd0; csr_wdata = 32'h0000_000C;
    in_valid = 1'b1; in_class = 3'd1; tag_a = 1'b1; tag_b = 1'b1; tag_rd = 1'b1;
    tick();
    csr_op = 2'b00; in_valid = 1'b0;
    check("old_mode_tag", 32'(out_tag), 1);
    check("policy_after_set", csr_rdata, 32'hE);
    send(1, 1'b1, 1'b1, 1'b1);
    check("clear_mode_tag", 32'(out_tag), 0);

    // Counter saturation at 3
    csr(2'b01, 2'd2, 32'h0);
    check("count_zeroed", csr_rdata, 0);
    for (int k = 0; k < 4; k++) begin
      send(0, 1'b1, 1'b1, 1'b0);
      check("sat_trap", 32'(trap), 1);
      check("sat_count", csr_rdata, (k + 1 > 3) ? 3 : k + 1);
      ack();
    end

    // Counter clear wins over a simultaneous trap increment
    csr_op = 2'b11; csr_sel = 2'd2; csr_wdata = 32'h0;
    in_valid = 1'b1; in_class = 3'd0; tag_a = 1'b0; tag_b = 1'b1; tag_rd = 1'b0;
    tick();
    csr_op = 2'b00; in_valid = 1'b0;
    check("clr_win_trap", 32'(trap), 1);
    check("clr_win_count", csr_rdata, 0);
    ack();

    // Out-of-range class: OLD mode, never checked
    csr(2'b01, 2'd1, 32'hFFFF_FFFF);
    check("mask_all", csr_rdata, 32'h7F);
    send(7, 1'b1, 1'b1, 1'b1);
    check("cls7_trap", 32'(trap), 0);
    check("cls7_valid", 32'(out_valid), 1);
    check("cls7_tag1", 32'(out_tag), 1);
    send(7, 1'b1, 1'b1, 1'b0);
    check("cls7_tag0", 32'(out_tag), 0);

    // AND mode on class 2
    csr(2'b11, 2'd1, 32'hFF);
    csr(2'b01, 2'd0, 32'h0000_0010);
    check("policy_and", csr_rdata, 32'h10);
    send(2, 1'b1, 1'b0, 1'b1);
    check("and_tag0", 32'(out_tag), 0);
    send(2, 1'b1, 1'b1, 1'b0);
    check("and_tag1", 32'(out_tag), 1);
    tick();

    // Randomised traffic checked by the model
    for (int n = 0; n < 300; n++) begin
      csr_op    = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 0)) : 2'b00;
      csr_sel   = 2'($urandom_range(3, 0));
      csr_wdata = $urandom;
      in_valid  = 1'($urandom_range(1, 0));
      in_class  = 3'($urandom_range(7, 0));
      tag_a     = 1'($urandom_range(1, 0));
      tag_b     = 1'($urandom_range(1, 0));
      tag_rd    = 1'($urandom_range(1, 0));
      out_ready = ($urandom_range(3, 0) != 0);
      trap_ack  = ($urandom_range(3, 0) == 0);
      tick();
    end
    csr_op = 2'b00; in_valid = 1'b0; trap_ack = 1'b0; out_ready = 1'b1;
    tick();
    if (trap) ack();
    tick();

    // Reset while a trap is pending
    csr(2'b01, 2'd1, 32'h1);
    send(0, 1'b1, 1'b0, 1'b0);
    check("pre_rst_trap", 32'(trap), 1);
    csr_sel = 2'd0;
    rst = 1'b1;
    tick();
    check("rst_trap_cleared", 32'(trap), 0);
    check("rst_trap_class", 32'(trap_class), 0);
    check("rst_valid_cleared", 32'(out_valid), 0);
    check("rst_out_tag", 32'(out_tag), 0);
    check("rst_policy_value", csr_rdata, 0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
